// File: rtl/alpha_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset/bubble defaults,
// and the widths agreed with the instruction memory.
// No logic; imported by the fetch unit, its IF/ID register and the bus interface.
package alpha_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0]   RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [INST_WIDTH-1:0] NOP_INST_DEFAULT     = 32'h0000_0013; // addi x0,x0,0

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_TRAP = 2'd2
  } fetch_state_t;

  // Instruction fetches must land on 4-byte boundaries.
  function automatic logic word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, hazard/execute controls,
// IF/ID register outputs and trap report.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface fetch_unit_if
  import alpha_pkg::*;
#(
  parameter int PC_WIDTH_LENGTH   = PC_WIDTH,
  parameter int INST_WIDTH_LENGTH = INST_WIDTH
);
  logic [PC_WIDTH_LENGTH-1:0]   PC;
  logic [INST_WIDTH_LENGTH-1:0] inst;
  logic                         stall;
  logic                         redirect;
  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc;
  logic                         if_id_valid;
  logic [INST_WIDTH_LENGTH-1:0] if_id_inst;
  logic [PC_WIDTH_LENGTH-1:0]   if_id_pc;
  logic [PC_WIDTH_LENGTH-1:0]   if_id_pc4;
  logic                         misalign_trap;
  logic [PC_WIDTH_LENGTH-1:0]   trap_pc;

  modport master (
    output PC, if_id_valid, if_id_inst, if_id_pc, if_id_pc4, misalign_trap, trap_pc,
    input  inst, stall, redirect, redirect_pc
  );

  modport slave (
    input  PC, if_id_valid, if_id_inst, if_id_pc, if_id_pc4, misalign_trap, trap_pc,
    output inst, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: captures fetched word with its pc and pc+4.
// Latency: one edge from load to outputs. Priority bubble > load > hold.
// Ports: clk/rst_n, load/bubble controls, inst_in/pc_in, registered valid/inst/pc/pc4.
module if_id_reg
  import alpha_pkg::*;
#(
  parameter int                          PC_WIDTH_LENGTH   = PC_WIDTH,
  parameter int                          INST_WIDTH_LENGTH = INST_WIDTH,
  parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST         = NOP_INST_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         bubble,
  input  logic [INST_WIDTH_LENGTH-1:0] inst_in,
  input  logic [PC_WIDTH_LENGTH-1:0]   pc_in,
  output logic                         valid,
  output logic [INST_WIDTH_LENGTH-1:0] inst,
  output logic [PC_WIDTH_LENGTH-1:0]   pc,
  output logic [PC_WIDTH_LENGTH-1:0]   pc4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= '0;
      pc4   <= '0;
    end else if (bubble) begin
      // pc/pc4 deliberately left alone: only valid/inst mark the slot empty
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= inst_in;
      pc    <= pc_in;
      pc4   <= pc_in + PC_WIDTH_LENGTH'(4); // wraps modulo 2^width
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, feeds instruction memory, fills IF/ID; traps misaligned redirects.
// Latency: word at PC in cycle n appears on if_id_* after the next edge; redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall; stall ignored in BOOT/TRAP.
// Ports: clk, rst_n, bus (fetch_unit_if.master: PC/inst, stall, redirect, IF/ID, trap).
module fetch_unit
  import alpha_pkg::*;
#(
  parameter int                          PC_WIDTH_LENGTH   = PC_WIDTH,
  parameter int                          INST_WIDTH_LENGTH = INST_WIDTH,
  parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_VECTOR     = RESET_VECTOR_DEFAULT,
  parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST         = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.master bus
);

  fetch_state_t                state, state_n;
  logic [PC_WIDTH_LENGTH-1:0]  pc_q, pc_n;
  logic [PC_WIDTH_LENGTH-1:0]  trap_pc_q, trap_pc_n;
  logic                        load, bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH_BOOT;
      pc_q      <= RESET_VECTOR;
      trap_pc_q <= '0;
    end else begin
      state     <= state_n;
      pc_q      <= pc_n;
      trap_pc_q <= trap_pc_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc_q;
    trap_pc_n = trap_pc_q;
    load      = 1'b0;
    bubble    = 1'b0;
    case (state)
      // BOOT shares RUN's redirect handling; otherwise it just spends one edge.
      FETCH_BOOT, FETCH_RUN: begin
        if (bus.redirect) begin
          bubble  = 1'b1;
          state_n = FETCH_RUN;
          if (word_aligned(bus.redirect_pc[1:0])) begin
            pc_n = bus.redirect_pc;
          end else begin
            trap_pc_n = bus.redirect_pc;
            state_n   = FETCH_TRAP;
          end
        end else if (state == FETCH_BOOT) begin
          state_n = FETCH_RUN;
        end else if (!bus.stall) begin
          load = 1'b1;
          pc_n = pc_q + PC_WIDTH_LENGTH'(4);
        end
      end
      FETCH_TRAP: begin
        bubble = 1'b1;
        if (bus.redirect) begin
          if (word_aligned(bus.redirect_pc[1:0])) begin
            pc_n    = bus.redirect_pc;
            state_n = FETCH_RUN;
          end else begin
            trap_pc_n = bus.redirect_pc;
          end
        end
      end
      default: begin
        state_n = FETCH_BOOT;
      end
    endcase
  end

  assign bus.PC            = pc_q;
  assign bus.misalign_trap = (state == FETCH_TRAP);
  assign bus.trap_pc       = trap_pc_q;

  if_id_reg #(
    .PC_WIDTH_LENGTH  (PC_WIDTH_LENGTH),
    .INST_WIDTH_LENGTH(INST_WIDTH_LENGTH),
    .NOP_INST         (NOP_INST)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .bubble (bubble),
    .inst_in(bus.inst),
    .pc_in  (pc_q),
    .valid  (bus.if_id_valid),
    .inst   (bus.if_id_inst),
    .pc     (bus.if_id_pc),
    .pc4    (bus.if_id_pc4)
  );

endmodule
